// File: rtl/memload_pkg.sv
// Shared types and constants for the framed-stream memory loader.
// LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to I/D frames.
package memload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CNT,
        DATA,
        WRITE,
        CSUM,
        RUN
    } state_e;

    localparam logic [7:0] HDR_IMEM = 8'h49;
    localparam logic [7:0] HDR_DMEM = 8'h44;
    localparam logic [7:0] HDR_GO   = 8'h47;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic is_ready_state(state_e s);
        return s inside {IDLE, ADDR, CNT, DATA, CSUM};
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream in, memory write port out.
// slave = loader side, master = host/memory side.
interface mem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_sel,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_sel,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/word_assembler.sv
// Big-endian 8->32 shift register; first byte lands in bits [31:24].
// word_full pulses with the handshake of the last byte of a word.
module word_assembler
    import memload_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear) begin
            idx_d = '0;
        end else if (byte_en) begin
            word_d = {word_q[23:0], byte_in};
            idx_d  = idx_q + 2'd1;
        end
    end

    assign word      = word_q;
    assign word_full = byte_en & ~clear & (idx_q == LAST);

endmodule

// File: rtl/mem_loader.sv
// Framed-stream boot loader: writes imem/dmem words, releases cpu on GO.
// LOADER_CHECKSUM_EN: I/D frames end in an XOR checksum byte.
module mem_loader
    import memload_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         reset,
    mem_loader_if.slave  bus,
    output logic         cpu_reset,
    output logic         err,
    output logic         done
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_e TAIL = CSUM;
`else
    localparam state_e TAIL = IDLE;
`endif

    state_e             state_q, state_d;
    logic               live_q;
    logic               hi_q, hi_d;
    logic               sel_q, sel_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               hs;
    logic               is_load_hdr;
    logic [CNT_W-1:0]   cnt_shift;
    logic [31:0]        word;
    logic               word_full;

    assign hs          = bus.in_valid & bus.in_ready;
    assign is_load_hdr = (bus.in_data == HDR_IMEM) ||
                         (bus.in_data == HDR_DMEM);
    assign cnt_shift   = CNT_W'({cnt_q[7:0], bus.in_data});

    word_assembler u_wa (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == IDLE),
        .byte_en   (hs && state_q == DATA),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q <= 1'b0;
            hi_q   <= 1'b0;
            sel_q  <= 1'b0;
            err_q  <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            live_q <= 1'b1;
            hi_q   <= hi_d;
            sel_q  <= sel_d;
            err_q  <= err_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (hs && is_load_hdr) begin
                    state_d = ADDR;
                end else if (hs && bus.in_data == HDR_GO) begin
                    state_d = RUN;
                end
            end
            ADDR: begin
                if (hs && hi_q) state_d = CNT;
            end
            CNT: begin
                if (hs && hi_q) begin
                    state_d = (cnt_shift == '0) ? TAIL : DATA;
                end
            end
            DATA: begin
                if (word_full) state_d = WRITE;
            end
            WRITE: begin
                state_d = (cnt_q == CNT_W'(1)) ? TAIL : DATA;
            end
            CSUM: begin
                if (hs) state_d = IDLE;
            end
            RUN: state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        sel_d  = sel_q;
        err_d  = err_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q;
        if (hs && state_q inside {ADDR, CNT, DATA}) begin
            csum_d = csum_q ^ bus.in_data;
        end
`endif
        unique case (state_q)
            IDLE: begin
                hi_d = 1'b0;
                if (hs && is_load_hdr) begin
                    sel_d  = (bus.in_data == HDR_DMEM);
                    addr_d = '0;
                    cnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = bus.in_data;
`endif
                end else if (hs && bus.in_data != HDR_GO) begin
                    err_d = 1'b1;
                end
            end
            ADDR: begin
                if (hs) begin
                    hi_d   = ~hi_q;
                    addr_d = ADDR_W'({addr_q[7:0], bus.in_data});
                    // Word-aligned by construction: drop byte offset bits.
                    if (hi_q) addr_d[1:0] = 2'b00;
                end
            end
            CNT: begin
                if (hs) begin
                    hi_d  = ~hi_q;
                    cnt_d = cnt_shift;
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(BYTES_PER_WORD);
                cnt_d  = cnt_q - CNT_W'(1);
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (hs && bus.in_data != csum_q) err_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.in_ready  = live_q & is_ready_state(state_q);
        bus.mem_we    = (state_q == WRITE);
        bus.mem_sel   = sel_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = word;
        done          = (state_q == RUN);
        cpu_reset     = (state_q != RUN);
        err           = err_q;
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed + randomized frames checked against a frame-level write model.
module tb_mem_loader;
    import memload_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, err, done;

    always #5 clk = ~clk;

    mem_loader_if bus ();

    mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .err       (err),
        .done      (done)
    );

    typedef struct packed {
        logic        sel;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;
    logic we_prev = 1'b0;
    logic exp_err = 1'b0;
    wr_t  exp_q[$];
    wr_t  got_q[$];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            got_q.push_back({bus.mem_sel, bus.mem_addr, bus.mem_wdata});
            if (bus.in_ready || we_prev) viol <= viol + 1;
        end
        we_prev <= bus.mem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] hdr, input logic [15:0] addr,
                         input logic [15:0] cnt, input logic [31:0] w[$],
                         input bit bad);
        logic [7:0] cs;
        logic [7:0] hdrs[5];
        hdrs = '{hdr, addr[15:8], addr[7:0], cnt[15:8], cnt[7:0]};
        cs = 8'h00;
        foreach (hdrs[i]) begin
            send_byte(hdrs[i]);
            cs ^= hdrs[i];
        end
        for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back({hdr == HDR_DMEM, addr + 16'(4 * i), w[i]});
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[i][8*k +: 8]);
                cs ^= w[i][8*k +: 8];
            end
        end
        if (CSUM_EN) begin
            send_byte(bad ? ~cs : cs);
            if (bad) exp_err = 1'b1;
        end
    endtask

    task automatic compare(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_wcount"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) chk({tag, "_write"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, bus.mem_we}, 64'd0);
        chk({tag, "_sel_addr"}, {47'd0, bus.mem_sel, bus.mem_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
        chk({tag, "_err_done"}, {62'd0, err, done}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals(tag);
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_after"}, {63'd0, bus.in_ready}, 64'd1);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        logic [7:0]  hdr;
        logic [15:0] addr;
        logic [15:0] cnt;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        do_reset("rst");

        w = '{32'h20080005, 32'h20090007};
        frame(HDR_IMEM, 16'h0000, 16'd2, w, 1'b0);
        compare("imem2");

        w = '{32'hDEADBEEF};
        frame(HDR_DMEM, 16'h0018, 16'd1, w, 1'b0);
        compare("dmem1");
        chk("still_held", {62'd0, cpu_reset, done}, 64'd2);

        for (int f = 0; f < 8; f++) begin
            hdr  = ($urandom_range(1) == 1) ? HDR_DMEM : HDR_IMEM;
            addr = 16'($urandom) & 16'hFFFC;
            cnt  = 16'($urandom_range(3));
            w.delete();
            for (int i = 0; i < int'(cnt); i++) w.push_back($urandom);
            frame(hdr, addr, cnt, w, 1'b0);
            compare("rand");
        end

        w = '{32'h01020304, 32'hA5A55A5A};
        frame(HDR_DMEM, 16'hFFFC, 16'd2, w, 1'b0);
        compare("wrap");

        w.delete();
        frame(HDR_IMEM, 16'h0100, 16'd0, w, 1'b0);
        compare("cnt0");

        w = '{32'h11223344};
        frame(HDR_DMEM, 16'h0000, 16'd1, w, 1'b0);
        compare("csum_ok");
        frame(HDR_DMEM, 16'h0000, 16'd1, w, 1'b1);
        compare("csum_bad");

        send_byte(HDR_DMEM);
        send_byte(8'h00);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        do_reset("midrst2");
        compare("midrst_nowrite");

        send_byte(8'h55);
        exp_err = 1'b1;
        compare("badhdr");

        w = '{32'hCAFEF00D};
        frame(HDR_IMEM, 16'h0040, 16'd1, w, 1'b0);
        compare("after_bad");

        send_byte(HDR_GO);
        @(negedge clk);
        chk("go_cpu_reset", {63'd0, cpu_reset}, 64'd0);
        chk("go_done", {63'd0, done}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = HDR_IMEM;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        compare("run_nowrite");
        chk("we_protocol", 64'(viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
